mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sub-word load/store engine for the MEM stage of the MIPS pipeline. It sits between the EX/MEM pipeline register and data memory. For stores (`sb`, `sh`, `sw`) it narrows 32-bit register data into byte lanes with byte-enables. For loads (`lb`, `lbu`, `lh`, `lhu`, `lw`) it selects the addressed lanes from the returned word and sign- or zero-extends them back to 32 bits. Memory may take a variable number of cycles; a request/ack handshake stalls the unit until memory answers.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: the pipeline presents an access.
- `req_ready`  out  1: the unit can accept an access (IDLE only).
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  `ADDR_W`: byte address.
- `req_wdata`  in  32: store source register value.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  32: extended load result; 0 for stores and faults.
- `resp_fault`  out  1: misaligned access or illegal size; qualified by `resp_valid`.
- `mem_req`  out  1: memory request, held until acknowledged.
- `mem_we`  out  1: memory write.
- `mem_addr`  out  `ADDR_W`: word-aligned address, with `[1:0]` forced to 00.
- `mem_be`  out  4: byte enables; bit i = byte lane i (little-endian).
- `mem_wdata`  out  32: lane-replicated store data.
- `mem_ack`  in  1: memory done; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32: read word.

## Operation
- State machine: IDLE → BUSY → RESP → IDLE.
  - IDLE: `req_ready`=1. When `req_valid`=1, the unit captures `req_*` into registers.
  - If the access is legal, the next state is BUSY.
  - If it faults, the next state is RESP with fault=1, and no memory access is issued.
- Fault conditions:
  - size 11;
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠00.
- BUSY: `mem_req`=1. All `mem_*` outputs are driven from captured registers and held stable.
  - On `mem_ack`=1, the unit registers the extracted and extended load data, then moves to RESP.
  - `mem_ack` is sampled only in BUSY; it is ignored in every other state.
- RESP: `resp_valid`=1 for exactly one cycle, then the unit returns to IDLE.
- Store lane rules, with lane offset o = `addr[1:0]`:
  - byte: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=0001<<o.
  - half: `mem_wdata`={2{wdata[15:0]}}, `mem_be`=0011<<o.
  - word: `mem_wdata`=wdata, `mem_be`=1111.
- Loads drive `mem_be`=1111 and `mem_we`=0.
- Load extraction:
  - byte: b = rdata[8o+7:8o], result = unsigned ? {24'b0,b} : {{24{b[7]}},b}.
  - half: h = rdata[16(o/2)+15:16(o/2)], extended to 32 bits by the same rule.
  - word: passed through unchanged.
- Store responses: `resp_rdata`=0, `resp_fault`=0.

## Timing
- Reset values: `req_ready`=1, state=IDLE.
- Every other output resets to 0: `resp_valid`, `resp_rdata`, `resp_fault`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`.
- Legal access accepted at edge 0:
  - `mem_req` is asserted from cycle 1.
  - If `mem_ack` arrives in cycle k (k≥1), `resp_valid` is high in cycle k+1.
  - `req_ready` returns to 1 in cycle k+2.
- Minimum latency from accept to response is 2 cycles. Zero-wait memory (ack in cycle 1) gives a throughput of one access per 3 cycles.
- Faulting access accepted at edge 0: `resp_valid`/`resp_fault` are high in cycle 1, and `mem_req` never rises.
- `req_*` are ignored while `req_ready`=0.
- Reset mid-access: `mem_req` and `resp_valid` drop asynchronously. The in-flight access is abandoned with no response, and a late `mem_ack` is ignored.

## Structure
- Package `mau_pkg`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum {S_IDLE, S_BUSY, S_RESP};
  - a function `misaligned(size, addr_lo)`.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension. Inputs are the rdata word, size, offset and unsigned flag; the output is the 32-bit result. It is instantiated once, in BUSY's ack path.

## Test plan
- `sb` with wdata=0x000000A5, addr=0x1003 → `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5; `resp_valid` 1 cycle after ack, fault=0.
- `lb` with addr=0x2001, ack in cycle 3 with rdata=0x12348056 → resp_rdata=0xFFFFFF80 in cycle 4. Repeating as `lbu` → 0x00000080.
- `lh` with addr=0x3002, rdata=0x9ABC0000 → 0xFFFF9ABC. `lhu` → 0x00009ABC.
- `sw` with addr=0x4002 → `mem_req` stays 0; `resp_fault`=1 in cycle 1. size=11 with any address behaves the same.
- `lw` with ack delayed 5 cycles → `mem_*` stable throughout and `req_ready`=0. A `req_valid` pulse mid-wait is ignored.
- Assert `rst_n`=0 during BUSY, then pulse `mem_ack` after release → no `resp_valid`; outputs at reset values; the next request completes normally.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings, FSM states and the alignment check for mem_access_unit.
//   SZ_*        : req_size encodings (byte, half, word, illegal)
//   state_t     : control FSM states
//   misaligned(): 1 when an access must fault instead of touching memory
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    // The illegal size encoding is folded in here so that a single test decides
    // whether an access faults.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_ILL)
            || (size == SZ_HALF && addr_lo[0])
            || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the addressed byte/half lane out of a read word and sign- or zero-extends it.
//   rdata       in  32 : word returned by memory
//   size        in  2  : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset      in  2  : byte offset of the access inside the word
//   is_unsigned in  1  : 1 = zero-extend, 0 = sign-extend
//   result      out 32 : extended load value
module load_extend
    import mau_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_sel  = rdata[{offset, 3'b000} +: 8];
        // Half accesses are 2-byte aligned, so only offset[1] picks the lane.
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_sign = ~is_unsigned & byte_sel[7];
        half_sign = ~is_unsigned & half_sel[15];
        result    = (size == SZ_BYTE) ? {{24{byte_sign}}, byte_sel} :
                    (size == SZ_HALF) ? {{16{half_sign}}, half_sel} :
                                        rdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage sub-word load/store engine between the EX/MEM register and data memory.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : pipeline access handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata : captured access description
//   resp_valid/rdata/fault : one-cycle completion pulse with extended load data or fault
//   mem_req/we/addr/be/wdata : memory request, held until mem_ack
//   mem_ack/rdata      : memory completion, read word valid with the ack
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    state_t            state_next;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        offset;
    logic              accept;
    logic              req_fault;
    logic [31:0]       load_data;
    logic [3:0]        store_be;
    logic [31:0]       store_wdata;

    assign offset    = addr_q[1:0];
    assign accept    = (state == S_IDLE) && req_valid;
    assign req_fault = misaligned(req_size, req_addr[1:0]);

    load_extend u_load_extend (
        .rdata       (mem_rdata),
        .size        (size_q),
        .offset      (offset),
        .is_unsigned (uns_q),
        .result      (load_data)
    );

    // Lane steering for stores; loads always enable the whole word.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = wdata_q;
        if (we_q) begin
            case (size_q)
                SZ_BYTE: begin
                    store_be    = 4'b0001 << offset;
                    store_wdata = {4{wdata_q[7:0]}};
                end
                SZ_HALF: begin
                    store_be    = 4'b0011 << offset;
                    store_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    store_be    = 4'b1111;
                    store_wdata = wdata_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Memory-side outputs are zero outside BUSY so a reset or an idle unit
    // never presents a stale request.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = 32'h0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_fault ? S_RESP : S_BUSY;
            end
            S_BUSY: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_be    = store_be;
                mem_wdata = store_wdata;
                if (mem_ack)
                    state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end else if (accept) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            resp_fault <= req_fault;
        end else if (state == S_BUSY && mem_ack && !we_q) begin
            resp_rdata <= load_data;
        end else if (state == S_RESP) begin
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a transaction-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    bit          chk_en = 1'b0;
    logic        e_ready, e_mreq, e_we, e_rv, e_fault;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;

    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic [3:0]  cap_be;
    logic        cap_rv, cap_fault, cap_mreq;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_fault(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [1:0] sz, input int o);
        if (!we || sz == 2'd2) return 4'hF;
        return (sz == 2'd0) ? 4'(1 << o) : 4'(3 << o);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] r, input logic [1:0] sz, input int o, input bit uns);
        logic [31:0] v;
        if (sz == 2'd2) return r;
        if (sz == 2'd0) begin
            v = (r >> (8 * o)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else begin
            v = (r >> (16 * (o / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("mem_req", 32'(mem_req), 32'(e_mreq));
            if (e_mreq) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_be", 32'(mem_be), 32'(e_be));
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_rv) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_fault", 32'(resp_fault), 32'(e_fault));
            end
        end
    end

    task automatic set_idle();
        e_ready = 1'b1;
        e_mreq  = 1'b0;
        e_rv    = 1'b0;
    endtask

    // Called just after a rising edge with the unit idle; returns in the
    // same position once the unit is idle again.
    task automatic access(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] rd, input bit poke);
        bit f;
        int o;
        f = m_fault(sz, addr);
        o = int'(addr % 4);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'd3; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        e_ready = 1'b0;
        if (f) begin
            e_rv = 1'b1; e_fault = 1'b1; e_rdata = 32'h0; e_mreq = 1'b0;
            cap_rv = resp_valid; cap_fault = resp_fault; cap_rdata = resp_rdata; cap_mreq = mem_req;
        end else begin
            e_mreq = 1'b1; e_we = we; e_addr = addr - (addr % 4);
            e_be = m_be(we, sz, o); e_wdata = m_wdata(sz, wdata); e_rv = 1'b0;
            cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_mreq = mem_req;
            for (int i = 0; i < delay; i++) begin
                if (poke && i == 1) begin
                    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h4002;
                end
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
            mem_ack = 1'b1; mem_rdata = rd;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
            e_mreq = 1'b0; e_rv = 1'b1; e_fault = 1'b0;
            e_rdata = we ? 32'h0 : m_load(rd, sz, o, uns);
            cap_rv = resp_valid; cap_fault = resp_fault; cap_rdata = resp_rdata;
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    // Idle cycle with a stray ack, which must be ignored outside BUSY.
    task automatic gap();
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, " resp_fault"}, 32'(resp_fault), 32'd0);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_be"}, 32'(mem_be), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        access(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 0, 32'h0, 1'b0);
        chk("sb mem_addr", cap_addr, 32'h0000_1000);
        chk("sb mem_be", 32'(cap_be), 32'h8);
        chk("sb mem_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb resp_valid", 32'(cap_rv), 32'd1);
        chk("sb resp_fault", 32'(cap_fault), 32'd0);
        gap();

        access(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 2, 32'h1234_8056, 1'b0);
        chk("lb rdata", cap_rdata, 32'hFFFF_FF80);
        chk("lb mem_be", 32'(cap_be), 32'hF);
        access(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 2, 32'h1234_8056, 1'b0);
        chk("lbu rdata", cap_rdata, 32'h0000_0080);
        gap();

        access(1'b0, 2'd1, 1'b0, 32'h3002, 32'h0, 1, 32'h9ABC_0000, 1'b0);
        chk("lh rdata", cap_rdata, 32'hFFFF_9ABC);
        access(1'b0, 2'd1, 1'b1, 32'h3002, 32'h0, 0, 32'h9ABC_0000, 1'b0);
        chk("lhu rdata", cap_rdata, 32'h0000_9ABC);

        access(1'b1, 2'd2, 1'b0, 32'h4002, 32'h1111_2222, 0, 32'h0, 1'b0);
        chk("sw misaligned fault", 32'(cap_fault), 32'd1);
        chk("sw misaligned mem_req", 32'(cap_mreq), 32'd0);
        access(1'b0, 2'd3, 1'b0, 32'h5000, 32'h0, 0, 32'h0, 1'b0);
        chk("size11 fault", 32'(cap_fault), 32'd1);
        chk("size11 mem_req", 32'(cap_mreq), 32'd0);
        access(1'b0, 2'd1, 1'b1, 32'h3001, 32'h0, 0, 32'h0, 1'b0);
        chk("lh odd fault", 32'(cap_fault), 32'd1);

        access(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 5, 32'hCAFE_F00D, 1'b1);
        chk("lw rdata", cap_rdata, 32'hCAFE_F00D);
        gap();

        access(1'b1, 2'd1, 1'b0, 32'h7002, 32'h1234_BEEF, 1, 32'h0, 1'b0);
        chk("sh mem_be", 32'(cap_be), 32'hC);
        chk("sh mem_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh resp_rdata", cap_rdata, 32'h0);
        access(1'b1, 2'd2, 1'b0, 32'h7004, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
        chk("sw mem_be", 32'(cap_be), 32'hF);
        access(1'b1, 2'd0, 1'b0, 32'h7006, 32'hFFFF_FF3C, 3, 32'h0, 1'b0);
        chk("sb o2 mem_be", 32'(cap_be), 32'h4);
        access(1'b0, 2'd0, 1'b0, 32'h8003, 32'h0, 0, 32'h7F00_0000, 1'b0);
        chk("lb o3 rdata", cap_rdata, 32'h0000_007F);
        access(1'b0, 2'd1, 1'b0, 32'h8000, 32'h0, 0, 32'h0000_8001, 1'b0);
        chk("lh o0 rdata", cap_rdata, 32'hFFFF_8001);

        // Reset while BUSY: the access is dropped and a late ack does nothing.
        chk_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h9000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset mem_req", 32'(mem_req), 32'd0);
        chk("async reset resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late ack resp_valid", 32'(resp_valid), 32'd0);
            chk("late ack mem_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        check_reset_vals("post-reset");
        set_idle();
        chk_en = 1'b1;
        access(1'b0, 2'd0, 1'b1, 32'hA002, 32'h0, 1, 32'h00C3_0000, 1'b0);
        chk("post-reset lbu rdata", cap_rdata, 32'h0000_00C3);
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
